// File: rtl/alu_multicycle_if.sv
// Handshake bundle for the execute-stage ALU: operand/op request channel and result channel.
// The master side belongs to the pipeline, the slave side to the ALU.
interface alu_multicycle_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] reg1;
    logic [WIDTH-1:0] reg2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             ovf;
    logic             dz;

    modport master (
        output in_valid, op, reg1, reg2, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, ovf, dz
    );

    modport slave (
        input  in_valid, op, reg1, reg2, out_ready,
        output in_ready, out_valid, result, result_hi, zero, ovf, dz
    );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arithmetic plus iterative shift-add multiply and
// restoring divide on operand magnitudes, sign-corrected in a final FIX cycle.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    alu_multicycle_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_NOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(7);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(8);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(9);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(10);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(11);
    localparam logic [OPW-1:0] OP_MULU = OPW'(12);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(13);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(14);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [SHW-1:0]     cnt_reg;
    logic [WIDTH-1:0]   acc_hi_reg;
    logic [WIDTH-1:0]   acc_lo_reg;
    logic [WIDTH-1:0]   opb_reg;
    logic               is_div_reg;
    logic               q_neg_reg;
    logic               r_neg_reg;
    logic               dz_op_reg;

    logic [WIDTH-1:0]   result_reg;
    logic [WIDTH-1:0]   result_hi_reg;
    logic               zero_reg;
    logic               ovf_reg;
    logic               dz_reg;
    logic               out_valid_reg;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ovf;
    logic               mul_op;
    logic               div_op;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               accept;

    assign a         = bus.reg1;
    assign b         = bus.reg2;
    assign sh        = b[SHW-1:0];
    assign sum       = a + b;
    assign diff      = a - b;
    assign mul_op    = (bus.op == OP_MUL) || (bus.op == OP_MULU);
    assign div_op    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign signed_op = (bus.op == OP_MUL) || (bus.op == OP_DIV);
    assign a_neg     = signed_op && a[WIDTH-1];
    assign b_neg     = signed_op && b[WIDTH-1];
    assign abs_a     = a_neg ? -a : a;
    assign abs_b     = b_neg ? -b : b;

    assign bus.in_ready = rst_n && (state_reg == S_IDLE) &&
                          (!out_valid_reg || bus.out_ready) && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  sc_res = a << sh;
            OP_SRL:  sc_res = a >> sh;
            OP_SRA:  sc_res = $signed(a) >>> sh;
            default: sc_res = '0;
        endcase
    end

    // Iteration datapaths: {carry,hi,lo} shifts right for multiply, {hi,lo} shifts left for divide.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;

    assign mul_sum    = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : '0);
    assign div_rem_sh = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_diff   = div_rem_sh - {1'b0, opb_reg};
    assign div_ok     = !div_diff[WIDTH];

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   fix_hi;

    assign prod     = {acc_hi_reg, acc_lo_reg};
    assign prod_fix = q_neg_reg ? -prod : prod;
    assign q_fix    = q_neg_reg ? -acc_lo_reg : acc_lo_reg;
    assign r_fix    = r_neg_reg ? -acc_hi_reg : acc_hi_reg;
    assign fix_lo   = is_div_reg ? q_fix : prod_fix[WIDTH-1:0];
    assign fix_hi   = is_div_reg ? r_fix : prod_fix[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            acc_hi_reg    <= '0;
            acc_lo_reg    <= '0;
            opb_reg       <= '0;
            is_div_reg    <= 1'b0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            dz_op_reg     <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            zero_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            dz_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (out_valid_reg && bus.out_ready)
                out_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (mul_op || div_op) begin
                            acc_hi_reg <= '0;
                            acc_lo_reg <= abs_a;
                            opb_reg    <= abs_b;
                            cnt_reg    <= '0;
                            is_div_reg <= div_op;
                            // A zero divisor leaves the raw quotient all ones and the remainder
                            // |reg1|; only the remainder sign restore is wanted then.
                            q_neg_reg  <= (div_op && (b == '0)) ? 1'b0 : (a_neg ^ b_neg);
                            r_neg_reg  <= a_neg;
                            dz_op_reg  <= div_op && (b == '0);
                            state_reg  <= mul_op ? S_MUL : S_DIV;
                        end else begin
                            result_reg    <= sc_res;
                            result_hi_reg <= '0;
                            zero_reg      <= (sc_res == '0);
                            ovf_reg       <= sc_ovf;
                            dz_reg        <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi_reg <= mul_sum[WIDTH:1];
                    acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
                    cnt_reg    <= cnt_reg + SHW'(1);
                    if (cnt_reg == SHW'(WIDTH-1))
                        state_reg <= S_FIX;
                end
                S_DIV: begin
                    acc_hi_reg <= div_ok ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0];
                    acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], div_ok};
                    cnt_reg    <= cnt_reg + SHW'(1);
                    if (cnt_reg == SHW'(WIDTH-1))
                        state_reg <= S_FIX;
                end
                S_FIX: begin
                    result_reg    <= fix_lo;
                    result_hi_reg <= fix_hi;
                    zero_reg      <= (fix_lo == '0);
                    ovf_reg       <= 1'b0;
                    dz_reg        <= dz_op_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= S_DONE;
                end
                S_DONE: state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.result_hi = result_hi_reg;
    assign bus.zero      = zero_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.dz        = dz_reg;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle: single-cycle ops, MUL/DIV latency and results,
// backpressure, flush and mid-operation reset.
module tb_alu_multicycle;
    logic clk;
    logic rst_n;
    logic flush;
    int   errors;
    int   checks;

    alu_multicycle_if #(.WIDTH(32), .OPW(4)) bus ();

    alu_multicycle #(.WIDTH(32), .OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_single(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res,
                             input logic exp_zero, input logic exp_ovf);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.reg1     = a;
        bus.reg2     = b;
        #0;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_result"}, 64'(bus.result), 64'(exp_res));
        chk({tag, "_hi"}, 64'(bus.result_hi), 64'd0);
        chk({tag, "_zero"}, 64'(bus.zero), 64'(exp_zero));
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        $display("txn %s op=%0d a=%h b=%h -> res=%h zero=%b ovf=%b", tag, op, a, b,
                 bus.result, bus.zero, bus.ovf);
    endtask

    task automatic do_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_lo,
                            input logic [31:0] exp_hi, input logic exp_dz);
        int n;
        int busy_bad;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.reg1     = a;
        bus.reg2     = b;
        #0;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        n        = 0;
        busy_bad = 0;
        while (n < 100) begin
            if (bus.in_ready) busy_bad++;
            tick();
            n++;
            if (bus.out_valid) break;
        end
        chk({tag, "_latency"}, 64'(n), 64'd33);
        chk({tag, "_busy_ready"}, 64'(busy_bad), 64'd0);
        chk({tag, "_lo"}, 64'(bus.result), 64'(exp_lo));
        chk({tag, "_hi"}, 64'(bus.result_hi), 64'(exp_hi));
        chk({tag, "_dz"}, 64'(bus.dz), 64'(exp_dz));
        $display("txn %s op=%0d a=%h b=%h -> lo=%h hi=%h dz=%b after %0d edges", tag, op, a, b,
                 bus.result, bus.result_hi, bus.dz, n);
        tick();
        chk({tag, "_consumed"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.reg1      = '0;
        bus.reg2      = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        rst_n = 1'b1;
        #0;
        chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

        do_single("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
        do_single("sub_zero", 4'd1, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
        do_single("slt_b2b", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        do_single("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        do_single("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        do_single("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0);
        do_single("or", 4'd3, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1'b0);
        do_single("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0);
        do_single("nor", 4'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_single("sll_mask", 4'd8, 32'd1, 32'd33, 32'd2, 1'b0, 1'b0);
        do_single("srl", 4'd9, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0);
        do_single("sra", 4'd10, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0);
        do_single("reserved", 4'd15, 32'h1234, 32'h5678, 32'd0, 1'b1, 1'b0);

        do_multi("mul_s", 4'd11, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
        do_multi("mulu", 4'd12, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        do_multi("mul_nn", 4'd11, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15, 32'd0, 1'b0);
        do_multi("div_s", 4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_multi("divu_dz", 4'd14, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1);
        do_multi("div_min", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        do_multi("div_s_dz", 4'd13, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1);
        do_multi("divu", 4'd14, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0);

        // Backpressure: result held while the consumer stalls, then swapped on one edge.
        bus.out_ready = 1'b0;
        do_single("bp_first", 4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.op       = 4'd0;
        bus.reg1     = 32'd10;
        bus.reg2     = 32'd20;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_result", 64'(bus.result), 64'd3);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        #0;
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_swap_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_swap_result", 64'(bus.result), 64'd30);
        $display("txn bp_swap op=0 a=%h b=%h -> res=%h", 32'd10, 32'd20, bus.result);

        // Flush during a divide.
        bus.in_valid = 1'b1;
        bus.op       = 4'd13;
        bus.reg1     = 32'd100;
        bus.reg2     = 32'd7;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        #0;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        flush = 1'b0;
        #0;
        chk("flush_idle_ready", 64'(bus.in_ready), 64'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) pulses++;
            tick();
        end
        chk("flush_no_pulse", 64'(pulses), 64'd0);
        $display("txn flush_div op=13 a=%h b=%h -> pulses=%0d", 32'd100, 32'd7, pulses);
        do_single("after_flush", 4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);

        // Reset during a multiply.
        bus.in_valid = 1'b1;
        bus.op       = 4'd11;
        bus.reg1     = 32'd9;
        bus.reg2     = 32'd9;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) pulses++;
            tick();
        end
        chk("rst_no_pulse", 64'(pulses), 64'd0);
        $display("txn rst_mul op=11 a=%h b=%h -> pulses=%0d", 32'd9, 32'd9, pulses);
        do_single("after_rst", 4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
